// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter predictor with tagged BTB, 1-cycle registered lookup.
// Optional gshare counter indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
    parameter int WordSize = 32,
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                fetch_valid,
    input  logic [WordSize-1:0] fetch_pc,
    output logic                pred_valid,
    output logic                pred_taken,
    output logic [WordSize-1:0] pred_pc,
    output logic [WordSize-1:0] pred_addr,
    input  logic                upd_valid,
    input  logic [WordSize-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [WordSize-1:0] upd_target
);
    localparam int Entries = 1 << IDX_BITS;
    localparam int TagW    = WordSize - IDX_BITS - 2;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
        logic [1:0] r;
        case ({up, c})
            3'b1_11: r = 2'b11;
            3'b0_00: r = 2'b00;
            3'b1_00, 3'b1_01, 3'b1_10: r = c + 2'd1;
            3'b0_01, 3'b0_10, 3'b0_11: r = c - 2'd1;
            default: r = c;
        endcase
        return r;
    endfunction

    logic [Entries-1:0]  valid_q, valid_d;
    logic [TagW-1:0]     tag_q    [Entries];
    logic [TagW-1:0]     tag_d    [Entries];
    logic [WordSize-1:0] target_q [Entries];
    logic [WordSize-1:0] target_d [Entries];
    logic [1:0]          ctr_q    [Entries];
    logic [1:0]          ctr_d    [Entries];

    logic                pred_valid_q, pred_valid_d;
    logic                pred_taken_q, pred_taken_d;
    logic [WordSize-1:0] pred_pc_q, pred_pc_d;
    logic [WordSize-1:0] pred_addr_q, pred_addr_d;

    logic [IDX_BITS-1:0] f_idx_s, f_cidx_s, u_idx_s, u_cidx_s;
    logic [TagW-1:0]     f_tag_s, u_tag_s;
    logic                f_hit_s, u_hit_s;
    logic                unused_bits_s;

    assign f_idx_s = fetch_pc[IDX_BITS+1:2];
    assign f_tag_s = fetch_pc[WordSize-1:IDX_BITS+2];
    assign u_idx_s = upd_pc[IDX_BITS+1:2];
    assign u_tag_s = upd_pc[WordSize-1:IDX_BITS+2];
    assign f_hit_s = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
    assign u_hit_s = valid_q[u_idx_s] && (tag_q[u_idx_s] == u_tag_s);
    assign unused_bits_s = ^upd_pc[1:0] ^ ((GHR_BITS > 0) ? 1'b0 : 1'b1);

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    // Counter index hashes the pre-shift history so same-cycle lookups see old GHR.
    assign f_cidx_s = f_idx_s ^ IDX_BITS'(ghr_q);
    assign u_cidx_s = u_idx_s ^ IDX_BITS'(ghr_q);

    // Next global history: shift in every resolved direction.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], upd_taken};
        end else begin
            ghr_d = ghr_q;
        end
    end

    // Global history register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ghr_q <= {GHR_BITS{1'b0}};
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign f_cidx_s = f_idx_s;
    assign u_cidx_s = u_idx_s;
`endif

    // Prediction from pre-update table contents; outputs hold while fetch is idle.
    always_comb begin
        pred_valid_d = fetch_valid;
        pred_taken_d = pred_taken_q;
        pred_pc_d    = pred_pc_q;
        pred_addr_d  = pred_addr_q;
        if (fetch_valid) begin
            pred_taken_d = f_hit_s && ctr_q[f_cidx_s][1];
            pred_pc_d    = fetch_pc;
            pred_addr_d  = f_hit_s ? target_q[f_idx_s] : (fetch_pc + WordSize'(4));
        end else begin
            pred_taken_d = pred_taken_q;
        end
    end

    // Training: hits move the counter, taken misses allocate, not-taken misses are ignored.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_valid && u_hit_s) begin
            ctr_d[u_cidx_s] = sat_ctr(ctr_q[u_cidx_s], upd_taken);
            if (upd_taken) begin
                target_d[u_idx_s] = upd_target;
            end else begin
                target_d[u_idx_s] = target_q[u_idx_s];
            end
        end else if (upd_valid && upd_taken) begin
            valid_d[u_idx_s]  = 1'b1;
            tag_d[u_idx_s]    = u_tag_s;
            target_d[u_idx_s] = upd_target;
            ctr_d[u_cidx_s]   = 2'b10;
        end else begin
            valid_d = valid_q;
        end
    end

    // Table and prediction registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q      <= {Entries{1'b0}};
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_pc_q    <= {WordSize{1'b0}};
            pred_addr_q  <= {WordSize{1'b0}};
            for (int i = 0; i < Entries; i++) begin
                tag_q[i]    <= {TagW{1'b0}};
                target_q[i] <= {WordSize{1'b0}};
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            target_q     <= target_d;
            ctr_q        <= ctr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_pc_q    <= pred_pc_d;
            pred_addr_q  <= pred_addr_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_pc    = pred_pc_q;
    assign pred_addr  = pred_addr_q;
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side producer of branch predictions consumed by the branch manager.
- Per fetch PC, emits registered taken/not-taken prediction plus predicted next address. Direct-mapped table of 2-bit saturating counters with a tagged branch target buffer (BTB).
- Trained by resolved branch outcomes from execute, on the same clock.

Parameters:
- WordSize, 32, width of PCs and addresses.
- IDX_BITS, 6, log2 of table entries (64); index = pc[IDX_BITS+1:2].
- GHR_BITS, 6, global history length; used only when BP_GSHARE_EN is defined; must be <= IDX_BITS.

Ports:
- clk  input  1  clock, all state on posedge.
- rstn  input  1  asynchronous active-low reset.
- fetch_valid  input  1  fetch_pc valid this cycle.
- fetch_pc  input  WordSize  PC being fetched.
- pred_valid  output  1  registered prediction valid.
- pred_taken  output  1  predicted direction for pred_pc.
- pred_pc  output  WordSize  PC the prediction belongs to.
- pred_addr  output  WordSize  predicted target (BTB target on hit, else pred_pc+4).
- upd_valid  input  1  resolved branch update strobe.
- upd_pc  input  WordSize  PC of resolved branch.
- upd_taken  input  1  actual direction.
- upd_target  input  WordSize  actual taken target.

Behaviour:
- Reset (rstn low, async): all counters = 2'b01 (weakly not-taken); all BTB valid bits = 0; pred_valid=0, pred_taken=0, pred_pc=0, pred_addr=0; GHR=0. Reset mid-operation discards all training.
- Entry: {valid, tag[WordSize-IDX_BITS-3:0], target[WordSize-1:0], ctr[1:0]}; tag = pc[WordSize-1:IDX_BITS+2].
- Lookup latency 1 cycle: at posedge with fetch_valid=1, register pred_pc=fetch_pc, pred_valid=1. hit = valid && tag match. pred_taken = hit && ctr[1]. pred_addr = hit ? target : fetch_pc+4 (mod 2^WordSize, wraps at top of address space).
- fetch_valid=0: pred_valid<=0; other prediction outputs hold.
- Update (posedge, upd_valid=1), at index of upd_pc:
  - Tag match and valid: ctr increments if upd_taken (saturates at 3), else decrements (saturates at 0).
  - upd_taken=1 with miss or invalid: allocate/replace. valid=1, tag written, target=upd_target, ctr=2'b10.
  - upd_taken=0 with miss: no change.
  - Taken hit: target overwritten with upd_target.
- Same index lookup and update in one cycle: lookup sees pre-update contents (read-before-write). Updated value visible from the next lookup.
- upd_pc/fetch_pc bits [1:0] are ignored.
- No speculative state; no flush input needed.

Optional Feature:
- BP_GSHARE_EN defined:
  - Counter index = pc[IDX_BITS+1:2] XOR zero-extended GHR[GHR_BITS-1:0]. BTB remains indexed by plain pc index.
  - GHR shifts left, inserting upd_taken, on each upd_valid.
  - Lookup in the same cycle uses the pre-shift GHR.
- Undefined: no GHR register; counters indexed by pc only.

Test Plan:
- Reset, then fetch 0x100 -> next cycle pred_valid=1, pred_taken=0, pred_pc=0x100, pred_addr=0x104.
- upd pc=0x100 taken target=0x200, then fetch 0x100 -> pred_taken=1, pred_addr=0x200; second taken update saturates ctr at 3.
- From ctr=3: two not-taken updates -> ctr=1, fetch 0x100 gives pred_taken=0, pred_addr=0x200 (hit, target retained).
- Aliasing: train 0x100 taken, fetch 0x200 (same index with IDX_BITS=6, different tag) -> pred_taken=0, pred_addr=0x204.
- Same-cycle fetch 0x100 and first taken update 0x100 -> that prediction not-taken; following fetch predicts taken to 0x200.
- fetch 0xFFFFFFFC untrained -> pred_addr=0x00000000; async rstn pulse mid-stream -> outputs zero immediately, prior training lost.
